// File: rtl/wb_stage_pkg.sv
// Shared constants for the write-back stage: default widths, load-op and FSM encodings.
package wb_stage_pkg;

    localparam int unsigned WB_DATA_WIDTH = 32;
    localparam int unsigned WB_ADDR_WIDTH = 5;

    localparam logic [2:0] LOAD_LB  = 3'b000;
    localparam logic [2:0] LOAD_LH  = 3'b001;
    localparam logic [2:0] LOAD_LW  = 3'b010;
    localparam logic [2:0] LOAD_LBU = 3'b100;
    localparam logic [2:0] LOAD_LHU = 3'b101;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_MEM_WAIT = 2'd1;
    localparam logic [1:0] S_WRITE    = 2'd2;

endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational load data alignment: selects the byte/halfword named by the
// address offset and sign- or zero-extends it; unknown load codes act as LW.
module load_align
    import wb_stage_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = WB_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic [2:0]            load_op,
    input  logic [1:0]            byte_off,
    output logic [DATA_WIDTH-1:0] data_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = mem_rdata[{byte_off, 3'b000} +: 8];
        half_sel = mem_rdata[{byte_off[1], 4'b0000} +: 16];
        case (load_op)
            LOAD_LB:  data_c = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            LOAD_LH:  data_c = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
            LOAD_LBU: data_c = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
            LOAD_LHU: data_c = {{(DATA_WIDTH-16){1'b0}}, half_sel};
            default:  data_c = mem_rdata;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: retires one instruction at a time, waits on load data, and
// drives the register-file write port for one cycle. Optional perf counters: WB_PERF_CNT_EN.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = WB_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = WB_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic                  in_reg_we,
    input  logic [DATA_WIDTH-1:0] in_result,
    input  logic                  in_is_load,
    input  logic [2:0]            in_load_op,
    input  logic [1:0]            in_byte_off,
    output logic                  mem_read,
    input  logic                  mem_rdata_valid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  wb_done
`ifdef WB_PERF_CNT_EN
    ,
    output logic [31:0]           perf_wb_cnt,
    output logic [31:0]           perf_stall_cnt
`endif
);

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic                  accept;
    logic                  alu_wr;
    logic                  load_wr;
    logic [ADDR_WIDTH-1:0] rd_q;
    logic                  reg_we_q;
    logic [2:0]            load_op_q;
    logic [1:0]            byte_off_q;
    logic [DATA_WIDTH-1:0] load_data_c;

    load_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_load_align (
        .mem_rdata (mem_rdata),
        .load_op   (load_op_q),
        .byte_off  (byte_off_q),
        .data_c    (load_data_c)
    );

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Next state plus the two write sources: non-loads write on accept, loads on valid data.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        alu_wr    = 1'b0;
        load_wr   = 1'b0;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    accept    = 1'b1;
                    alu_wr    = !in_is_load;
                    state_nxt = in_is_load ? S_MEM_WAIT : S_WRITE;
                end
            end
            S_MEM_WAIT: begin
                if (mem_rdata_valid) begin
                    load_wr   = 1'b1;
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            in_ready   <= 1'b1;
            mem_read   <= 1'b0;
            wb_done    <= 1'b0;
            rf_wen     <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            rd_q       <= '0;
            reg_we_q   <= 1'b0;
            load_op_q  <= LOAD_LW;
            byte_off_q <= 2'b00;
        end else begin
            in_ready <= (state_nxt == S_IDLE);
            mem_read <= (state_nxt == S_MEM_WAIT);
            wb_done  <= (state_nxt == S_WRITE);
            rf_wen   <= 1'b0;
            if (accept) begin
                rd_q       <= in_rd;
                reg_we_q   <= in_reg_we;
                load_op_q  <= in_load_op;
                byte_off_q <= in_byte_off;
            end
            if (alu_wr) begin
                rf_wen   <= in_reg_we && (in_rd != '0);
                rf_waddr <= in_rd;
                rf_wdata <= in_result;
            end
            if (load_wr) begin
                rf_wen   <= reg_we_q && (rd_q != '0);
                rf_waddr <= rd_q;
                rf_wdata <= load_data_c;
            end
        end
    end

`ifdef WB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_wb_cnt    <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if ((state == S_WRITE) && rf_wen)
                perf_wb_cnt <= perf_wb_cnt + 32'd1;
            if ((state == S_MEM_WAIT) && !mem_rdata_valid)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the multi-cycle MIPS CPU, sitting directly upstream of the register file. It accepts one retiring instruction at a time. For loads it waits on the data-memory read response and sign/zero-extends and aligns the returned word. It then drives the register file write port (`rf_wen`/`rf_waddr`/`rf_wdata`) for exactly one cycle.

## Interface
Parameters:
- `DATA_WIDTH`, 32, register/data width
- `ADDR_WIDTH`, 5, register index width

Ports:
- `clk`  in  1  clock; all state changes on posedge
- `rst`  in  1  synchronous, active-low reset
- `in_valid`  in  1  retiring instruction present
- `in_ready`  out  1  stage can accept; high only in IDLE
- `in_rd`  in  ADDR_WIDTH  destination register
- `in_reg_we`  in  1  instruction writes a register
- `in_result`  in  DATA_WIDTH  ALU/shift result (non-load)
- `in_is_load`  in  1  instruction is a load
- `in_load_op`  in  3  load type encoding
- `in_byte_off`  in  2  load address bits [1:0]
- `mem_read`  out  1  data-memory read request, level
- `mem_rdata_valid`  in  1  read data valid this cycle
- `mem_rdata`  in  DATA_WIDTH  read word, little-endian
- `rf_wen`  out  1  register file write enable
- `rf_waddr`  out  ADDR_WIDTH  register file write index
- `rf_wdata`  out  DATA_WIDTH  register file write data
- `wb_done`  out  1  one-cycle retire pulse
- `perf_wb_cnt`  out  32  only with `WB_PERF_CNT_EN`
- `perf_stall_cnt`  out  32  only with `WB_PERF_CNT_EN`

## Operation
- States: IDLE, MEM_WAIT, WRITE.
- IDLE: `in_ready`=1. On `in_valid`, the stage captures `in_rd`, `in_reg_we`, `in_result`, `in_load_op` and `in_byte_off`.
  - If `in_is_load`=1, next state is MEM_WAIT.
  - Otherwise, next state is WRITE.
- MEM_WAIT: `mem_read`=1 held continuously.
  - `mem_rdata_valid` is sampled only in this state; it is ignored elsewhere.
  - On valid, the aligned data is captured and the next state is WRITE.
- WRITE: registered outputs are active for this one cycle.
  - `rf_wen` = captured `in_reg_we` AND (`rd` != 0).
  - `wb_done`=1 unconditionally.
  - Next state is IDLE.
- Load encodings:
  - 000 LB: sign-extend `mem_rdata[8*off+:8]`.
  - 001 LH: sign-extend `mem_rdata[16*off[1]+:16]`; `off[0]` is ignored.
  - 010 LW: full word.
  - 100 LBU, 101 LHU: zero-extend as above.
  - All other codes are treated as LW.
- `rf_waddr`/`rf_wdata` hold their last written values outside WRITE; `rf_wen` is 0 outside WRITE.

## Timing
- Reset (`rst`=0 at posedge):
  - State goes to IDLE.
  - `rf_wen`, `rf_waddr`, `rf_wdata`, `wb_done`, `mem_read` are 0.
  - Counters are 0.
- Reset mid-operation abandons the instruction: no write and no `wb_done`.
- Non-load latency: accept at edge N; `rf_wen`/`wb_done` are high during cycle N+1.
- Load latency:
  - `mem_read` rises the cycle after accept.
  - If `mem_rdata_valid` is seen at edge M, `rf_wen` is high during cycle M+1.
  - Zero-wait memory (valid in the first MEM_WAIT cycle) gives 2-cycle total latency.
- Throughput:
  - Back-to-back non-loads accept every 2 cycles.
  - `in_ready`=0 in MEM_WAIT and WRITE; `in_valid` there is ignored and not queued.
- `mem_read` drops in the cycle after valid is sampled.

## Configuration
- Macro: `WB_PERF_CNT_EN`.
- Defined:
  - `perf_wb_cnt` increments on each WRITE cycle with `rf_wen`=1.
  - `perf_stall_cnt` increments on each MEM_WAIT cycle with `mem_rdata_valid`=0.
  - Both are 32-bit, wrap modulo 2^32, and clear only on reset.
- Undefined: the ports and counter logic are absent; all other behaviour is identical.

## Structure
- Shared package holds:
  - load-op encodings (LB/LH/LW/LBU/LHU);
  - state encoding (IDLE/MEM_WAIT/WRITE);
  - `DATA_WIDTH`/`ADDR_WIDTH` defaults.
- One combinational sub-module, `load_align`, maps (`mem_rdata`, `load_op`, `byte_off`) to the extended word.
- The FSM and capture registers stay in `wb_stage`.

## Test plan
- ALU retire: `rd`=5, `reg_we`=1, `result`=0x1234_5678 → one cycle later `rf_wen`=1, `rf_waddr`=5, `rf_wdata`=0x1234_5678, `wb_done`=1.
- `$zero` write: `rd`=0, `reg_we`=1 → `wb_done`=1, `rf_wen`=0.
- LB with `off`=3, `mem_rdata`=0x80FF_0011 after 3 wait cycles → `rf_wdata`=0xFFFF_FF80; `perf_stall_cnt`=3.
- LHU with `off`=2, `mem_rdata`=0xBEEF_0000, zero-wait → `rf_wdata`=0x0000_BEEF, `rf_wen` in 2nd cycle after accept.
- `rst`=0 asserted while in MEM_WAIT, then `mem_rdata_valid`=1 → no `rf_wen`, no `wb_done`, `in_ready`=1 the cycle after reset releases.
- `in_valid` held high in MEM_WAIT → not accepted; exactly one `wb_done` per accepted instruction; `perf_wb_cnt` matches the count of writes.
